io_debounce: RTL and testbench
==============================

// Module: io_debounce
// PURPOSE
//  Input conditioning stage that feeds the core's memory-mapped input ports (sw, btn).
//  Synchronises raw board switches/keys, debounces them and detects key presses.
//  Exports zero-extended 32-bit words that plug straight into the LSU sw/btn inputs.
//  Keys also expose sticky "pressed" flags, so polling firmware never misses a short press.
// PARAMETERS
//  NSW            18     number of switch inputs, 1..32
//  NBTN           4      number of key inputs, 1..16
//  TICK_DIV       50000  clk cycles per debounce sample tick (1 ms at 50 MHz), >=2
//  DB_CNT         10     consecutive disagreeing ticks required to accept a new level, >=1
//  BTN_ACTIVE_LOW 1      1: invert raw keys, so a pressed key reads 1
//  SW_ACTIVE_LOW  0      1: invert raw switches
// PORTS
//  clk        in   1     system clock
//  rst        in   1     asynchronous, active-low reset
//  sw_raw     in   NSW   asynchronous board switches
//  btn_raw    in   NBTN  asynchronous board keys
//  clr_sticky in   NBTN  per-bit clear of the sticky press flags, sampled each clk
//  sw_o       out  32    [NSW-1:0] debounced switches; upper bits 0 -> LSU sw
//  btn_o      out  32    [NBTN-1:0] debounced keys; [16+NBTN-1:16] sticky flags; others 0 -> LSU btn
//  btn_rise   out  NBTN  1-cycle pulse per accepted key press
// BEHAVIOUR
//  - Reset (rst=0, async) clears all state:
//    - sync flops, prescaler, per-bit counters, stable levels, btn_rise and sticky flags all reset to 0
//    - therefore sw_o=0 and btn_o=0
//  - Polarity inversion is applied before the synchronisers. Logical level 1 = switch on / key pressed.
//  - Sync: 2-flop synchroniser per bit. Downstream logic uses only the second flop (s).
//  - Prescaler: presc counts 0..TICK_DIV-1 and wraps to 0.
//    - tick = (presc == TICK_DIV-1), combinational, high for exactly 1 cycle per period.
//  - Per bit: a counter cnt of width $clog2(DB_CNT+1) plus a stable register q.
//    - tick & s==q              -> cnt<=0
//    - tick & s!=q & cnt<DB_CNT-1 -> cnt<=cnt+1
//    - tick & s!=q & cnt==DB_CNT-1 -> q<=s, cnt<=0
//    - no tick                  -> hold
//    - Any agreeing tick restarts the count, so a glitch shorter than DB_CNT ticks never reaches q.
//  - Latency from a raw edge to q change: 2 clk of sync plus DB_CNT..DB_CNT+1 ticks.
//    - Worst case is 2 + (DB_CNT+1)*TICK_DIV clk.
//  - Key outputs are registered:
//    - btn_rise[i] is 1 in the same cycle q[i] becomes 1, only when q goes 0->1. Otherwise 0.
//    - sticky[i] is set by btn_rise[i] and cleared by clr_sticky[i]. If both happen in one cycle, set wins.
//  - A release (q 1->0) produces no pulse and leaves sticky unchanged.
//  - Switches get no rise or sticky logic.
//  - Mid-operation reset drops every in-progress count. After release, inputs re-qualify from 0.
//    - A key held through reset produces a fresh btn_rise once it is re-accepted.
//  - Outputs are never X after reset.
//  - Unused upper bits of sw_o/btn_o are constant 0.
// STRUCTURE
//  - Package io_pkg: IO_WORD_W=32, BTN_STICKY_LSB=16, default TICK_DIV/DB_CNT constants.
//  - Sub-module debounce_cell: one bit, containing the 2-flop sync, cnt, q and the rise output.
//    - Instantiated NSW+NBTN times via generate.
//    - Shares one prescaler tick, which lives in io_debounce.
//  - Top: prescaler, polarity inversion, sticky register, output zero-extension packing.
// TESTING  (bench uses TICK_DIV=4, DB_CNT=3, NSW=4, NBTN=2, BTN_ACTIVE_LOW=1)
//  1. Reset mid-count:
//     - btn_raw=2'b10 held for 6 clk, then rst pulsed low
//     - -> during and after reset, btn_o=0, btn_rise=0, cnt=0
//     - -> after release with btn_raw=2'b10 held, btn_o[0]=1 after the next DB_CNT accepting ticks
//  2. Clean press:
//     - btn_raw[0] goes 1->0 and is held
//     - -> btn_o[0]=1 within 2+16 clk
//     - -> btn_rise[0] is high for exactly 1 cycle
//     - -> btn_o[16]=1 and stays 1
//  3. Bounce:
//     - btn_raw[0] alternates each 5 clk for 40 clk, then stays released
//     - -> btn_o[0] never changes, btn_rise=0
//  4. Sticky clear:
//     - after scenario 2, clr_sticky=2'b01 for 1 clk -> btn_o[16]=0
//     - clr_sticky asserted in the same cycle as a new btn_rise[0] -> btn_o[16] remains 1
//  5. Switch path:
//     - sw_raw=4'hA held -> sw_o=32'h0000000A after 2+(DB_CNT+1)*TICK_DIV clk at most
//     - -> sw_o[31:4] always 0, btn_rise unaffected
//  6. Release:
//     - key released after qualification -> btn_o[0] goes 0, btn_rise stays 0, sticky bit unchanged

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the board input conditioning stage.
// Word layout matches the LSU sw/btn memory-mapped input ports.
package io_pkg;
  localparam int IO_WORD_W      = 32;
  localparam int BTN_STICKY_LSB = 16;
  localparam int DEF_NSW        = 18;
  localparam int DEF_NBTN       = 4;
  localparam int DEF_TICK_DIV   = 50000;
  localparam int DEF_DB_CNT     = 10;

  function automatic int cnt_width(input int db_cnt);
    return $clog2(db_cnt + 1);
  endfunction
endpackage

// File: rtl/debounce_cell.sv
// One debounced input bit: 2-flop synchroniser, tick-qualified agreement counter,
// stable level and a registered rising-edge pulse.
module debounce_cell
  import io_pkg::*;
#(
  parameter int DB_CNT = DEF_DB_CNT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_din,
  output logic o_q,
  output logic o_rise
);
  localparam int              CW       = cnt_width(DB_CNT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CNT - 1);

  logic          r_meta;
  logic          r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_q;
  logic          r_rise;
  logic          w_accept;

  assign w_accept = i_tick && (r_sync != r_q) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_cnt  <= '0;
      r_q    <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= i_din;
      r_sync <= r_meta;
      // Pulse lands in the same cycle q turns 1; releases never pulse.
      r_rise <= w_accept && r_sync;
      if (i_tick) begin
        if (r_sync == r_q) begin
          r_cnt <= '0;
        end else if (w_accept) begin
          r_q   <= r_sync;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_q    = r_q;
  assign o_rise = r_rise;
endmodule

// File: rtl/io_debounce.sv
// Board switch/key conditioning: shared sample prescaler, per-bit debounce cells,
// sticky key-press flags and zero-extended LSU words.
module io_debounce
  import io_pkg::*;
#(
  parameter int NSW            = DEF_NSW,
  parameter int NBTN           = DEF_NBTN,
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int DB_CNT         = DEF_DB_CNT,
  parameter bit BTN_ACTIVE_LOW = 1'b1,
  parameter bit SW_ACTIVE_LOW  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSW-1:0]       sw_raw,
  input  logic [NBTN-1:0]      btn_raw,
  input  logic [NBTN-1:0]      clr_sticky,
  output logic [IO_WORD_W-1:0] sw_o,
  output logic [IO_WORD_W-1:0] btn_o,
  output logic [NBTN-1:0]      btn_rise
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int NB = NSW + NBTN;

  logic [PW-1:0]   r_presc;
  logic            w_tick;
  logic [NB-1:0]   w_din;
  logic [NB-1:0]   w_q;
  logic [NSW-1:0]  w_sw_rise_unused;
  logic [NBTN-1:0] r_sticky;

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Inversion happens ahead of the synchronisers so every cell sees logical levels.
  assign w_din = {(BTN_ACTIVE_LOW ? ~btn_raw : btn_raw),
                  (SW_ACTIVE_LOW  ? ~sw_raw  : sw_raw)};

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_cell
      logic w_rise;
      debounce_cell #(
        .DB_CNT (DB_CNT)
      ) u_cell (
        .clk    (clk),
        .rst    (rst),
        .i_tick (w_tick),
        .i_din  (w_din[gi]),
        .o_q    (w_q[gi]),
        .o_rise (w_rise)
      );
      if (gi < NSW) begin : g_sw
        assign w_sw_rise_unused[gi] = w_rise;
      end else begin : g_btn
        assign btn_rise[gi-NSW] = w_rise;
      end
    end
  endgenerate

  // A press arriving with a clear request wins, so firmware never loses it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (r_sticky & ~clr_sticky) | btn_rise;
    end
  end

  always_comb begin
    sw_o                             = '0;
    sw_o[NSW-1:0]                    = w_q[NSW-1:0];
    btn_o                            = '0;
    btn_o[NBTN-1:0]                  = w_q[NB-1:NSW];
    btn_o[BTN_STICKY_LSB +: NBTN]    = r_sticky;
  end
endmodule

// File: tb/tb_io_debounce.sv
// Directed + randomized bench for io_debounce against a tick-count reference model.
module tb_io_debounce;
  localparam int NSW = 4, NBTN = 2, TICK_DIV = 4, DB_CNT = 3, NB = NSW + NBTN;
  localparam int MAX_LAT = 2 + (DB_CNT + 1) * TICK_DIV;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NSW-1:0]  sw_raw = '0;
  logic [NBTN-1:0] btn_raw = 2'b11;
  logic [NBTN-1:0] clr_sticky = '0;
  logic [31:0]     sw_o;
  logic [31:0]     btn_o;
  logic [NBTN-1:0] btn_rise;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a level is accepted once DB_CNT consecutive sample ticks
  // have disagreed with it, measured as tick-number distance from the last
  // agreeing tick (or last acceptance).
  int          m_k, m_ticks;
  int          m_ref[NB];
  logic [NB-1:0] m_line[$];
  logic [NB-1:0] m_q;
  logic [NBTN-1:0] m_rise, m_sticky;

  io_debounce #(
    .NSW(NSW), .NBTN(NBTN), .TICK_DIV(TICK_DIV), .DB_CNT(DB_CNT),
    .BTN_ACTIVE_LOW(1'b1), .SW_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .btn_raw(btn_raw),
    .clr_sticky(clr_sticky), .sw_o(sw_o), .btn_o(btn_o), .btn_rise(btn_rise)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [NB-1:0] logical_in();
    return {~btn_raw, sw_raw};
  endfunction

  task automatic model_reset();
    m_k = 0;
    m_ticks = 0;
    for (int b = 0; b < NB; b++) m_ref[b] = 0;
    m_line.delete();
    m_q = '0;
    m_rise = '0;
    m_sticky = '0;
  endtask

  task automatic model_edge();
    logic [NB-1:0]   s;
    logic [NBTN-1:0] rise_prev;
    if (!rst) begin
      model_reset();
      return;
    end
    s = (m_line.size() >= 2) ? m_line[m_line.size()-2] : '0;
    m_line.push_back(logical_in());
    if (m_line.size() > 2) void'(m_line.pop_front());
    rise_prev = m_rise;
    m_rise = '0;
    if ((m_k % TICK_DIV) == TICK_DIV - 1) begin
      m_ticks++;
      for (int b = 0; b < NB; b++) begin
        if (s[b] == m_q[b]) begin
          m_ref[b] = m_ticks;
        end else if (m_ticks - m_ref[b] >= DB_CNT) begin
          m_q[b] = s[b];
          m_ref[b] = m_ticks;
          if (b >= NSW && s[b]) m_rise[b-NSW] = 1'b1;
        end
      end
    end
    m_k++;
    m_sticky = (m_sticky & ~clr_sticky) | rise_prev;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("sw_o", sw_o, {28'b0, m_q[NSW-1:0]});
    chk("btn_o", btn_o, {14'b0, m_sticky, 14'b0, m_q[NB-1:NSW]});
    chk("btn_rise", {30'b0, btn_rise}, {30'b0, m_rise});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int found, rises, hold, sticky_before;
    model_reset();
    #1;
    chk("reset_sw_o", sw_o, 32'h0);
    chk("reset_btn_o", btn_o, 32'h0);
    run(3);
    rst = 1'b1;
    run(10);

    // Reset mid-count with key 0 pressed.
    btn_raw = 2'b10;
    run(6);
    rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_btn_o", btn_o, 32'h0);
    chk("midrst_rise", {30'b0, btn_rise}, 32'h0);
    run(4);
    rst = 1'b1;
    found = 0;
    rises = 0;
    for (int i = 0; i < MAX_LAT && found == 0; i++) begin
      step();
      if (btn_rise[0]) rises++;
      if (btn_o[0]) found = 1;
    end
    chk("requal_latency", found, 1);
    chk("requal_fresh_rise", rises, 1);
    chk("requal_btn1", {31'b0, btn_o[1]}, 32'h0);
    run(4);

    // Release, then a clean press of key 0.
    btn_raw = 2'b11;
    run(MAX_LAT);
    btn_raw = 2'b10;
    found = 0;
    rises = 0;
    for (int i = 0; i < MAX_LAT && found == 0; i++) begin
      step();
      if (btn_rise[0]) rises++;
      if (btn_o[0]) found = 1;
    end
    chk("press_latency", found, 1);
    for (int i = 0; i < 20; i++) begin
      step();
      if (btn_rise[0]) rises++;
    end
    chk("press_rise_once", rises, 1);
    chk("press_sticky", {31'b0, btn_o[16]}, 32'h1);

    // Release keeps sticky and emits no pulse.
    sticky_before = btn_o[16];
    btn_raw = 2'b11;
    found = 0;
    rises = 0;
    for (int i = 0; i < MAX_LAT + 4; i++) begin
      step();
      if (btn_rise != 2'b00) rises++;
      if (!btn_o[0]) found = 1;
    end
    chk("release_q", found, 1);
    chk("release_no_rise", rises, 0);
    chk("release_sticky", {31'b0, btn_o[16]}, sticky_before);

    // Sticky clear.
    clr_sticky = 2'b01;
    step();
    clr_sticky = 2'b00;
    step();
    chk("clear_sticky", {31'b0, btn_o[16]}, 32'h0);

    // Bounce: 5-clk alternation never qualifies.
    for (int seg = 0; seg < 8; seg++) begin
      btn_raw[0] = seg[0];
      for (int i = 0; i < 5; i++) begin
        step();
        chk("bounce_q", {31'b0, btn_o[0]}, 32'h0);
        chk("bounce_rise", {30'b0, btn_rise}, 32'h0);
      end
    end
    btn_raw = 2'b11;
    run(MAX_LAT);

    // Clear arriving with a new press: set wins.
    btn_raw = 2'b10;
    found = 0;
    for (int i = 0; i < MAX_LAT + 2 && found == 0; i++) begin
      step();
      if (btn_rise[0]) begin
        found = 1;
        clr_sticky = 2'b01;
        step();
        clr_sticky = 2'b00;
        chk("set_wins", {31'b0, btn_o[16]}, 32'h1);
      end
    end
    chk("set_wins_seen", found, 1);

    // Switch path.
    sw_raw = 4'hA;
    found = 0;
    for (int i = 0; i < MAX_LAT && found == 0; i++) begin
      step();
      chk("sw_upper", {4'b0, sw_o[31:4]}, 32'h0);
      chk("sw_no_rise", {30'b0, btn_rise}, 32'h0);
      if (sw_o == 32'h0000000A) found = 1;
    end
    chk("sw_latency", found, 1);

    // Randomized segments against the model.
    for (int seg = 0; seg < 60; seg++) begin
      hold = $urandom_range(1, 16);
      sw_raw = 4'($urandom);
      btn_raw = 2'($urandom);
      clr_sticky = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      step();
      clr_sticky = 2'b00;
      run(hold);
      if (seg == 30) begin
        rst = 1'b0;
        model_reset();
        #1;
        check_model();
        run(2);
        rst = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
